// File: rtl/reg_bank_pkg.sv
// Shared types and select encoding for the reg_bank register file.
// Selects 1..16 address r0..r15; 0 and 17..31 mean "no register".
package reg_bank_pkg;

    localparam int WORD_W = 16;
    localparam int SEL_W  = 5;
    localparam int NSEL   = 16;

    typedef logic [WORD_W-1:0] reg_word_t;
    typedef logic [SEL_W-1:0]  reg_sel_t;

    localparam reg_sel_t REG_SEL_NONE = 5'd0;
    localparam reg_sel_t REG_SEL_R0   = 5'd1;
    localparam reg_sel_t REG_SEL_MAX  = 5'd16;

    typedef enum logic {
        IDLE,
        PEND
    } state_e;

    function automatic logic sel_valid(reg_sel_t s);
        return (s >= REG_SEL_R0) && (s <= REG_SEL_MAX);
    endfunction

endpackage

// File: rtl/reg_sel_decoder.sv
// Encoded register select to one-hot write enable.
// Out-of-range selects produce an all-zero vector.
module reg_sel_decoder
    import reg_bank_pkg::*;
(
    input  reg_sel_t        sel_i,
    output logic [NSEL-1:0] onehot_o
);

    logic [3:0] idx;

    assign idx = 4'(sel_i - REG_SEL_R0);

    always_comb begin
        onehot_o = '0;
        if (sel_valid(sel_i)) begin
            onehot_o[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_bank.sv
// 16x16 register bank with ALU and delayed-load write-back plus load hazard stall.
// Build option REG_BANK_R0_ZERO_EN hardwires r0 to zero.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREGS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       wb_sel,
    input  logic [WIDTH-1:0] wb_data,
    input  logic [4:0]       ld_issue_sel,
    input  logic             ld_ret_valid,
    input  logic [WIDTH-1:0] ld_ret_data,
    input  logic [4:0]       src_a_sel,
    input  logic [4:0]       src_b_sel,
    output logic [WIDTH-1:0] r0,
    output logic [WIDTH-1:0] r1,
    output logic [WIDTH-1:0] r2,
    output logic [WIDTH-1:0] r3,
    output logic [WIDTH-1:0] r4,
    output logic [WIDTH-1:0] r5,
    output logic [WIDTH-1:0] r6,
    output logic [WIDTH-1:0] r7,
    output logic [WIDTH-1:0] r8,
    output logic [WIDTH-1:0] r9,
    output logic [WIDTH-1:0] r10,
    output logic [WIDTH-1:0] r11,
    output logic [WIDTH-1:0] r12,
    output logic [WIDTH-1:0] r13,
    output logic [WIDTH-1:0] r14,
    output logic [WIDTH-1:0] r15,
    output logic             ld_ready,
    output logic [4:0]       pend_sel,
    output logic             stall,
    output logic             err
);

    logic [WIDTH-1:0] regs_q [NREGS];
    state_e           state_q;
    reg_sel_t         pend_q;
    logic             err_q;
    logic             err_d;

    logic [NREGS-1:0] wb_oh;
    logic [NREGS-1:0] pend_oh;
    logic [NREGS-1:0] ld_wen;
    logic [NREGS-1:0] alu_wen;
    logic             issue_v;
    logic             ret_hit;
    logic             collide;

    reg_sel_decoder u_wb_dec (
        .sel_i    (wb_sel),
        .onehot_o (wb_oh)
    );

    reg_sel_decoder u_pend_dec (
        .sel_i    (pend_q),
        .onehot_o (pend_oh)
    );

`ifdef REG_BANK_R0_ZERO_EN
    assign issue_v = sel_valid(ld_issue_sel) && (ld_issue_sel != REG_SEL_R0);
    assign alu_wen = wb_oh & ~ld_wen & ~NREGS'(1);
`else
    assign issue_v = sel_valid(ld_issue_sel);
    assign alu_wen = wb_oh & ~ld_wen;
`endif

    assign ret_hit = (state_q == PEND) && ld_ret_valid;
    assign ld_wen  = ret_hit ? pend_oh : '0;
    assign collide = |(wb_oh & ld_wen);

    // Stray return, dropped second issue, or ALU/load collision.
    assign err_d = ((state_q == IDLE) && ld_ret_valid)
                || ((state_q == PEND) && !ld_ret_valid && issue_v)
                || collide;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (ld_wen[i]) begin
                    regs_q[i] <= ld_ret_data;
                end else if (alu_wen[i]) begin
                    regs_q[i] <= wb_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pend_q  <= REG_SEL_NONE;
            err_q   <= 1'b0;
        end else begin
            err_q <= err_d;
            unique case (state_q)
                IDLE: begin
                    if (issue_v) begin
                        state_q <= PEND;
                        pend_q  <= ld_issue_sel;
                    end
                end
                PEND: begin
                    if (ld_ret_valid) begin
                        if (issue_v) begin
                            pend_q <= ld_issue_sel;
                        end else begin
                            state_q <= IDLE;
                            pend_q  <= REG_SEL_NONE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    pend_q  <= REG_SEL_NONE;
                end
            endcase
        end
    end

    // pend_q is always a valid select while PEND, so invalid selects never match.
    assign stall = (state_q == PEND)
                && ((src_a_sel == pend_q)
                 || (src_b_sel == pend_q)
                 || (wb_sel == pend_q));

    assign ld_ready = (state_q == IDLE);
    assign pend_sel = pend_q;
    assign err      = err_q;

    assign r0  = regs_q[0];
    assign r1  = regs_q[1];
    assign r2  = regs_q[2];
    assign r3  = regs_q[3];
    assign r4  = regs_q[4];
    assign r5  = regs_q[5];
    assign r6  = regs_q[6];
    assign r7  = regs_q[7];
    assign r8  = regs_q[8];
    assign r9  = regs_q[9];
    assign r10 = regs_q[10];
    assign r11 = regs_q[11];
    assign r12 = regs_q[12];
    assign r13 = regs_q[13];
    assign r14 = regs_q[14];
    assign r15 = regs_q[15];

endmodule
